// File: rtl/uart_rx_pkt_ctrl_if.sv
// Byte-strobe input and payload stream output of the UART packet controller.
// master = byte source / payload sink, slave = uart_rx_pkt_ctrl.
interface uart_rx_pkt_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic [7:0] pay_data;
    logic       pay_valid;
    logic       pay_ready;
    logic       pay_last;
    logic       pkt_ok;
    logic       pkt_err;
    logic [2:0] err_code;

    modport master (
        output rx_data, rx_valid, rx_frame_err, pay_ready,
        input  pay_data, pay_valid, pay_last, pkt_ok, pkt_err, err_code
    );

    modport slave (
        input  rx_data, rx_valid, rx_frame_err, pay_ready,
        output pay_data, pay_valid, pay_last, pkt_ok, pkt_err, err_code
    );
endinterface

// File: rtl/uart_rx_pkt_ctrl.sv
// Frames UART bytes (SYNC, LEN, payload, CHK=XOR) and releases checked payload on a stream.
// Optional UART_PKT_STATS_EN adds saturating good_cnt/err_cnt outputs.
module uart_rx_pkt_ctrl #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned TIMEOUT_CYC = 250_000
) (
    input  logic              clk_fpga,
    input  logic              reset_n,
    uart_rx_pkt_ctrl_if.slave bus
`ifdef UART_PKT_STATS_EN
    ,
    output logic [15:0]       good_cnt,
    output logic [15:0]       err_cnt
`endif
);
    localparam int unsigned IDX_W = $clog2(MAX_LEN + 1);
    localparam int unsigned BUF_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAY, S_CHK, S_DRAIN} state_t;
    typedef enum logic [2:0] {
        E_NONE = 3'd0, E_CHK = 3'd1, E_LEN = 3'd2, E_TMO = 3'd3, E_FRAME = 3'd4, E_OVR = 3'd5
    } err_t;

    state_t             r_state, w_state_nx;
    err_t               r_err_code, w_code;
    logic               w_ok, w_err;
    logic               r_pkt_ok, r_pkt_err;
    logic [IDX_W-1:0]   r_idx, r_len;
    logic [7:0]         r_chk;
    logic [TMO_W-1:0]   r_tmo;
    logic [7:0]         r_buf [MAX_LEN];

    logic w_byte, w_len_bad, w_idx_last, w_tmo_hit, w_active, w_pay_valid, w_hs;

    assign w_byte      = bus.rx_valid && !bus.rx_frame_err;
    assign w_len_bad   = (bus.rx_data == 8'd0) || (bus.rx_data > 8'(MAX_LEN));
    assign w_idx_last  = (r_idx == r_len - IDX_W'(1));
    assign w_tmo_hit   = (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
    assign w_active    = (r_state == S_LEN) || (r_state == S_PAY) || (r_state == S_CHK);
    assign w_pay_valid = (r_state == S_DRAIN);
    assign w_hs        = w_pay_valid && bus.pay_ready;

    always_ff @(posedge clk_fpga or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    // A received byte always takes priority over a timeout landing in the same cycle.
    always_comb begin
        w_state_nx = r_state;
        w_ok       = 1'b0;
        w_err      = 1'b0;
        w_code     = E_NONE;
        unique case (r_state)
            S_IDLE: begin
                if (w_byte && (bus.rx_data == SYNC_BYTE)) w_state_nx = S_LEN;
            end
            S_LEN, S_PAY, S_CHK: begin
                if (bus.rx_valid && bus.rx_frame_err) begin
                    w_err = 1'b1; w_code = E_FRAME; w_state_nx = S_IDLE;
                end else if (bus.rx_valid) begin
                    if (r_state == S_LEN) begin
                        if (w_len_bad) begin
                            w_err = 1'b1; w_code = E_LEN; w_state_nx = S_IDLE;
                        end else begin
                            w_state_nx = S_PAY;
                        end
                    end else if (r_state == S_PAY) begin
                        if (w_idx_last) w_state_nx = S_CHK;
                    end else if (bus.rx_data == r_chk) begin
                        w_ok = 1'b1; w_state_nx = S_DRAIN;
                    end else begin
                        w_err = 1'b1; w_code = E_CHK; w_state_nx = S_IDLE;
                    end
                end else if (w_tmo_hit) begin
                    w_err = 1'b1; w_code = E_TMO; w_state_nx = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (bus.rx_valid) begin
                    w_err = 1'b1; w_code = E_OVR;
                end
                if (w_hs && w_idx_last) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_fpga or negedge reset_n) begin
        if (!reset_n) begin
            r_len      <= '0;
            r_idx      <= '0;
            r_chk      <= '0;
            r_tmo      <= '0;
            r_pkt_ok   <= 1'b0;
            r_pkt_err  <= 1'b0;
            r_err_code <= E_NONE;
        end else begin
            r_pkt_ok  <= w_ok;
            r_pkt_err <= w_err;
            if (w_err) r_err_code <= w_code;
            if (!w_active || bus.rx_valid || w_tmo_hit) r_tmo <= '0;
            else                                        r_tmo <= r_tmo + TMO_W'(1);
            unique case (r_state)
                S_LEN: begin
                    if (w_state_nx == S_PAY) begin
                        r_len <= bus.rx_data[IDX_W-1:0];
                        r_chk <= bus.rx_data;
                        r_idx <= '0;
                    end
                end
                S_PAY: begin
                    if (w_byte) begin
                        r_chk <= r_chk ^ bus.rx_data;
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_CHK:   r_idx <= '0;
                S_DRAIN: if (w_hs) r_idx <= r_idx + IDX_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_fpga) begin
        if ((r_state == S_PAY) && w_byte) r_buf[r_idx[BUF_W-1:0]] <= bus.rx_data;
    end

    assign bus.pay_valid = w_pay_valid;
    assign bus.pay_data  = w_pay_valid ? r_buf[r_idx[BUF_W-1:0]] : '0;
    assign bus.pay_last  = w_pay_valid && w_idx_last;
    assign bus.pkt_ok    = r_pkt_ok;
    assign bus.pkt_err   = r_pkt_err;
    assign bus.err_code  = r_err_code;

`ifdef UART_PKT_STATS_EN
    logic [15:0] r_good_cnt, r_err_cnt;

    always_ff @(posedge clk_fpga or negedge reset_n) begin
        if (!reset_n) begin
            r_good_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (r_pkt_ok && (r_good_cnt != '1))  r_good_cnt <= r_good_cnt + 16'd1;
            if (r_pkt_err && (r_err_cnt != '1))  r_err_cnt  <= r_err_cnt + 16'd1;
        end
    end

    assign good_cnt = r_good_cnt;
    assign err_cnt  = r_err_cnt;
`endif
endmodule
